instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: RESET_PC low two bits SHALL be zero; any other value is illegal configuration.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 Reset_L  in  1  asynchronous, active-low reset.
REQ-005 IMemReq  out  1  instruction-memory read request.
REQ-006 IMemAddr  out  32  instruction-memory byte address, equal to PC.
REQ-007 IMemAck  in  1  memory read complete; IMemData valid this cycle.
REQ-008 IMemData  in  32  instruction word from memory.
REQ-009 Instr  out  32  held instruction presented to the control unit.
REQ-010 InstrValid  out  1  Instr holds a fetched instruction.
REQ-011 InstrTaken  in  1  downstream consumes Instr this cycle.
REQ-012 Branch  in  1  branch instruction flag from control unit.
REQ-013 Zero  in  1  ALU zero flag.
REQ-014 Jump  in  1  jump instruction flag from control unit.
REQ-015 BranchOffset  in  32  sign-extended immediate of current instruction.
REQ-016 PC  out  32  address of current instruction.
REQ-017 PCPlus4  out  32  PC + 4, combinational.
REQ-018 InstrCount  out  32  count of instructions consumed.

Function
REQ-019 FSM states: IDLE, FETCH, HOLD.
REQ-020 IDLE: IMemReq=0, InstrValid=0; always go to FETCH next cycle.
REQ-021 FETCH: IMemReq=1, IMemAddr=PC; hold request and address stable until IMemAck=1.
REQ-022 FETCH with IMemAck=1: Instr<=IMemData, InstrValid<=1, go HOLD; IMemReq=0 from next cycle.
REQ-023 IMemAck while not in FETCH SHALL be ignored; Instr, state and PC unchanged.
REQ-024 HOLD with InstrTaken=0: Instr, InstrValid, PC held unchanged indefinitely.
REQ-025 HOLD with InstrTaken=1: sample Branch, Zero, Jump, BranchOffset this cycle; update PC; InstrValid<=0; InstrCount<=InstrCount+1; go FETCH.
REQ-026 Next-PC priority: Jump -> {PCPlus4[31:28], Instr[25:0], 2'b00}; else Branch&Zero -> PCPlus4 + (BranchOffset<<2); else PCPlus4.
REQ-027 All PC arithmetic is modulo 2^32; overflow discarded, no error.
REQ-028 PC[1:0] SHALL always be 00.
REQ-029 InstrTaken outside HOLD SHALL be ignored.
REQ-030 InstrCount wraps 32'hFFFF_FFFF -> 0.
REQ-031 Minimum fetch-to-fetch period: 3 cycles (FETCH w/ ack, HOLD w/ taken, FETCH).

Reset
REQ-032 Reset_L=0 SHALL immediately, without a clock edge, set PC=RESET_PC, state=IDLE, Instr=0, InstrValid=0, IMemReq=0, InstrCount=0.
REQ-033 Reset mid-FETCH abandons the request; an IMemAck arriving during or after reset while in IDLE is ignored.
REQ-034 After Reset_L rises: one cycle IDLE, then FETCH at RESET_PC.

Verification
REQ-035 Reset release, memory acks 2 cycles after IMemReq, InstrTaken=1 in HOLD, no branch/jump -> IMemAddr sequence 0x0,0x4,0x8; InstrCount 1,2,3.
REQ-036 PC=0x100, Branch=1, Zero=1, BranchOffset=32'hFFFF_FFFE at take -> next IMemAddr 0xFC; with Zero=0 -> 0x104.
REQ-037 PC=0x0040_0010, Instr=32'h0810_0000, Jump=1 and Branch=1, Zero=1 at take -> next PC 0x0040_0000 (jump wins).
REQ-038 HOLD with InstrTaken=0 for 10 cycles plus spurious IMemAck pulses -> Instr, PC, InstrValid unchanged; IMemReq stays 0.
REQ-039 Reset_L asserted mid-FETCH (no clock), ack arrives one cycle after release -> outputs at reset values immediately; ack ignored; first fetch at RESET_PC.
REQ-040 PC=32'hFFFF_FFFC, no branch/jump, taken -> next PC 0x0; InstrCount preloaded 32'hFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: the fetch unit drives request/address,
// memory returns an ack pulse with the instruction word.
`timescale 1ns/1ps

interface instr_fetch_unit_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   logic              IMemReq;
   logic [ADDR_W-1:0] IMemAddr;
   logic              IMemAck;
   logic [DATA_W-1:0] IMemData;

   modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemData);
   modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemData);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one word at PC, holds it until the control
// unit takes it, then computes the next PC (jump > taken branch > PC+4).
`timescale 1ns/1ps

module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                CLK,
   input  logic                Reset_L,
   instr_fetch_unit_if.master  imem,
   output logic [31:0]         Instr,
   output logic                InstrValid,
   input  logic                InstrTaken,
   input  logic                Branch,
   input  logic                Zero,
   input  logic                Jump,
   input  logic [31:0]         BranchOffset,
   output logic [31:0]         PC,
   output logic [31:0]         PCPlus4,
   output logic [31:0]         InstrCount
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t            state_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   instr_q;
   logic [XLEN-1:0]   count_q;
   logic              valid_q;
   logic              req_q;
   logic [XLEN-1:0]   pc_plus4;
   logic [XLEN-1:0]   next_pc;

   // A misaligned reset PC would break the word-aligned PC invariant.
   if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
      $error("instr_fetch_unit: RESET_PC must be word aligned");
   end

   assign pc_plus4 = pc_q + XLEN'(4);

   // Next PC selection; jump overrides a taken branch.
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + (BranchOffset << 2);
      end
   end

   // Fetch sequencer with registered request, instruction and PC state.
   always_ff @(posedge CLK or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
               req_q   <= 1'b1;
            end
            FETCH: begin
               if (imem.IMemAck) begin
                  instr_q <= imem.IMemData;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (InstrTaken) begin
                  pc_q    <= next_pc;
                  valid_q <= 1'b0;
                  count_q <= count_q + XLEN'(1);
                  req_q   <= 1'b1;
                  state_q <= FETCH;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign imem.IMemReq  = req_q;
   assign imem.IMemAddr = pc_q;
   assign Instr         = instr_q;
   assign InstrValid    = valid_q;
   assign PC            = pc_q;
   assign PCPlus4       = pc_plus4;
   assign InstrCount    = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed plus randomized bench for instr_fetch_unit against a
// transaction-level PC/count model.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset_L = 1'b1;
   logic        InstrTaken;
   logic        Branch;
   logic        Zero;
   logic        Jump;
   logic [31:0] BranchOffset;
   logic [31:0] Instr;
   logic        InstrValid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic [31:0] InstrCount;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   logic [31:0] m_instr;

   instr_fetch_unit_if bus ();

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .CLK          (CLK),
      .Reset_L      (Reset_L),
      .imem         (bus),
      .Instr        (Instr),
      .InstrValid   (InstrValid),
      .InstrTaken   (InstrTaken),
      .Branch       (Branch),
      .Zero         (Zero),
      .Jump         (Jump),
      .BranchOffset (BranchOffset),
      .PC           (PC),
      .PCPlus4      (PCPlus4),
      .InstrCount   (InstrCount)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Architectural next-PC rule written as plain arithmetic.
   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                              input logic b, input logic z, input logic j,
                                              input logic [31:0] off);
      logic [31:0] seq;
      seq = pc + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
      if (b && z) return seq + off * 32'd4;
      return seq;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_pc"},    PC, 32'h0);
      chk({tag, "_instr"}, Instr, 32'h0);
      chk({tag, "_valid"}, 32'(InstrValid), 32'd0);
      chk({tag, "_req"},   32'(bus.IMemReq), 32'd0);
      chk({tag, "_cnt"},   InstrCount, 32'h0);
   endtask

   // Serve one fetch: memory acks 'delay' cycles after the request is seen.
   task automatic fetch(input int delay, input logic [31:0] data);
      int n = 0;
      while (bus.IMemReq !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk("fetch_req",  32'(bus.IMemReq), 32'd1);
      chk("fetch_addr", bus.IMemAddr, m_pc);
      for (int i = 0; i < delay; i++) begin
         InstrTaken   = 1'($urandom);
         bus.IMemData = $urandom;
         tick();
         chk("wait_req",   32'(bus.IMemReq), 32'd1);
         chk("wait_addr",  bus.IMemAddr, m_pc);
         chk("wait_valid", 32'(InstrValid), 32'd0);
         chk("wait_cnt",   InstrCount, m_cnt);
      end
      InstrTaken   = 1'b0;
      bus.IMemData = data;
      bus.IMemAck  = 1'b1;
      tick();
      bus.IMemAck  = 1'b0;
      bus.IMemData = $urandom;
      m_instr = data;
      chk("ack_instr", Instr, m_instr);
      chk("ack_valid", 32'(InstrValid), 32'd1);
      chk("ack_req",   32'(bus.IMemReq), 32'd0);
      chk("ack_pc",    PC, m_pc);
   endtask

   // Stall in HOLD for 'hold' cycles with noise, then take with given flags.
   task automatic take(input logic b, input logic z, input logic j,
                       input logic [31:0] off, input int hold);
      for (int i = 0; i < hold; i++) begin
         InstrTaken   = 1'b0;
         bus.IMemAck  = 1'($urandom);
         bus.IMemData = $urandom;
         Branch       = 1'($urandom);
         Zero         = 1'($urandom);
         Jump         = 1'($urandom);
         BranchOffset = $urandom;
         tick();
         chk("hold_instr", Instr, m_instr);
         chk("hold_pc",    PC, m_pc);
         chk("hold_valid", 32'(InstrValid), 32'd1);
         chk("hold_req",   32'(bus.IMemReq), 32'd0);
         chk("hold_cnt",   InstrCount, m_cnt);
      end
      bus.IMemAck  = 1'b0;
      Branch       = b;
      Zero         = z;
      Jump         = j;
      BranchOffset = off;
      InstrTaken   = 1'b1;
      chk("pcplus4", PCPlus4, m_pc + 32'd4);
      tick();
      InstrTaken = 1'b0;
      Branch     = 1'b0;
      Zero       = 1'b0;
      Jump       = 1'b0;
      m_pc  = model_next(m_pc, m_instr, b, z, j, off);
      m_cnt = m_cnt + 32'd1;
      chk("take_pc",    PC, m_pc);
      chk("take_valid", 32'(InstrValid), 32'd0);
      chk("take_cnt",   InstrCount, m_cnt);
      chk("take_req",   32'(bus.IMemReq), 32'd1);
      chk("take_addr",  bus.IMemAddr, m_pc);
      chk("take_align", 32'(PC[1:0]), 32'd0);
   endtask

   task automatic random_round();
      logic [31:0] off;
      off = 32'($urandom_range(0, 63)) - 32'd32;
      fetch($urandom_range(0, 3), $urandom);
      take(1'($urandom), 1'($urandom), 1'($urandom), off, $urandom_range(0, 3));
   endtask

   initial begin
      logic [31:0] off;
      InstrTaken   = 1'b0;
      Branch       = 1'b0;
      Zero         = 1'b0;
      Jump         = 1'b0;
      BranchOffset = 32'h0;
      bus.IMemAck  = 1'b0;
      bus.IMemData = 32'h0;

      // Power-on reset, ack noise while in reset and during the IDLE cycle.
      #2 Reset_L = 1'b0;
      #1 check_reset_outputs("por");
      bus.IMemAck = 1'b1;
      tick();
      tick();
      Reset_L = 1'b1;
      bus.IMemData = 32'hDEAD_BEEF;
      m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0;
      chk("idle_req", 32'(bus.IMemReq), 32'd0);
      tick();
      bus.IMemAck = 1'b0;
      chk("idle_ack_instr", Instr, 32'h0);
      chk("idle_ack_valid", 32'(InstrValid), 32'd0);
      chk("first_req",  32'(bus.IMemReq), 32'd1);
      chk("first_addr", bus.IMemAddr, 32'h0);

      // Sequential fetches, ack two cycles after request.
      for (int k = 0; k < 3; k++) begin
         chk("seq_addr", bus.IMemAddr, 32'(k * 4));
         fetch(2, $urandom);
         take(1'b0, 1'b0, 1'b0, 32'h0, 0);
         chk("seq_cnt", InstrCount, 32'(k + 1));
      end

      // Jump to 0x100, then taken and untaken backward branch.
      fetch(1, 32'h0000_0040);
      take(1'b0, 1'b0, 1'b1, 32'h0, 0);
      chk("jmp_0x100", PC, 32'h0000_0100);
      fetch(0, $urandom);
      take(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE, 1);
      chk("br_taken_addr", bus.IMemAddr, 32'h0000_00FC);
      fetch(0, $urandom);
      take(1'b0, 1'b0, 1'b0, 32'h0, 0);
      chk("back_0x100", PC, 32'h0000_0100);
      fetch(2, $urandom);
      take(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 0);
      chk("br_untaken_addr", bus.IMemAddr, 32'h0000_0104);

      // Jump beats a taken branch.
      fetch(1, 32'h0010_0004);
      take(1'b0, 1'b0, 1'b1, 32'h0, 0);
      chk("at_0x400010", PC, 32'h0040_0010);
      fetch(1, 32'h0810_0000);
      take(1'b1, 1'b1, 1'b1, 32'h0000_0100, 0);
      chk("jmp_wins", PC, 32'h0040_0000);

      // Long stall in HOLD with spurious acks.
      fetch(3, $urandom);
      take(1'b0, 1'b0, 1'b0, 32'h0, 10);

      // Branch to the top word, then wrap PC and counter.
      off = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
      fetch(0, $urandom);
      take(1'b1, 1'b1, 1'b0, off, 0);
      chk("at_top", PC, 32'hFFFF_FFFC);
      fetch(1, $urandom);
      force dut.count_q = 32'hFFFF_FFFF;
      #1;
      release dut.count_q;
      m_cnt = 32'hFFFF_FFFF;
      chk("cnt_preload", InstrCount, 32'hFFFF_FFFF);
      take(1'b0, 1'b0, 1'b0, 32'h0, 0);
      chk("pc_wrap",  PC, 32'h0);
      chk("cnt_wrap", InstrCount, 32'h0);

      // Randomized traffic against the model.
      for (int r = 0; r < 25; r++) random_round();

      // Reset asserted mid-fetch between clock edges.
      tick();
      chk("midfetch_req", 32'(bus.IMemReq), 32'd1);
      Reset_L = 1'b0;
      #1 check_reset_outputs("async");
      tick();
      tick();
      Reset_L = 1'b1;
      m_pc = 32'h0; m_cnt = 32'h0; m_instr = 32'h0;
      bus.IMemAck  = 1'b1;
      bus.IMemData = 32'hCAFE_F00D;
      tick();
      bus.IMemAck = 1'b0;
      chk("post_rst_instr", Instr, 32'h0);
      chk("post_rst_valid", 32'(InstrValid), 32'd0);
      chk("post_rst_addr",  bus.IMemAddr, 32'h0);
      fetch(2, $urandom);
      take(1'b0, 1'b0, 1'b0, 32'h0, 0);
      chk("post_rst_next", PC, 32'h0000_0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
